// File: rtl/cam_pingpong_wr_ctrl.sv
// Camera-to-packet-RAM write controller: ping-pong banks filled at HDR_BYTES offset, plus send scheduling.
// Optional feature macro: SEQ_TAG_EN (per-send 16-bit sequence tag on send_seq).
module cam_pingpong_wr_ctrl #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 11,
  parameter int HDR_BYTES     = 50,
  parameter int PAYLOAD_BYTES = 1280,
  parameter int DROP_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              frame_done,
  input  logic              eth_finish,
  output logic              ram_wr_en,
  output logic              ram_wr_bank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              send_req,
  output logic              send_bank,
  output logic              send_rom,
  output logic [15:0]       send_seq,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);
  typedef enum logic {W_FILL = 1'b0, W_STALL = 1'b1} wstate_e;
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} sstate_e;

  localparam int                CNT_W    = $clog2(PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [ADDR_W-1:0] HDR_ADDR = ADDR_W'(HDR_BYTES);

  wstate_e           wstate_q, wstate_d;
  sstate_e           sstate_q, sstate_d;
  logic              wbank_q, wbank_d;
  logic [1:0]        full_q, full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              marker_q, marker_d;
  logic              stg_v_q, stg_v_d;
  logic              stg_bank_q, stg_bank_d;
  logic [ADDR_W-1:0] stg_addr_q, stg_addr_d;
  logic [DATA_W-1:0] stg_data_q, stg_data_d;
  logic              send_req_d, send_bank_d, send_rom_d, overflow_d;
  logic [DROP_W-1:0] drop_cnt_d;

  logic       fin_s, clr_mark_s, job_s, pick_rom_s, pick_bank_s;
  logic [1:0] clr_bank_s, full_free_s;

  // A finishing bank send frees its flag before any same-edge completion looks at it.
  assign fin_s       = (sstate_q == S_BUSY) && eth_finish;
  assign clr_mark_s  = fin_s && send_rom;
  assign clr_bank_s  = (fin_s && !send_rom) ? (send_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_free_s = full_q & ~clr_bank_s;
  assign job_s       = (sstate_q == S_IDLE) && ((full_q != 2'b00) || marker_q);
  assign pick_rom_s  = (full_q == 2'b00);
  assign pick_bank_s = (full_q == 2'b11) ? ~wbank_q : full_q[1];

  always_comb begin
    wstate_d   = wstate_q;
    sstate_d   = sstate_q;
    wbank_d    = wbank_q;
    full_d     = full_free_s;
    cnt_d      = cnt_q;
    stg_v_d    = 1'b0;
    stg_bank_d = stg_bank_q;
    stg_addr_d = stg_addr_q;
    stg_data_d = stg_data_q;
    overflow_d = overflow;
    drop_cnt_d = drop_cnt;
    send_req_d  = send_req;
    send_bank_d = send_bank;
    send_rom_d  = send_rom;

    if (clr_mark_s) marker_d = 1'b0;
    else if (frame_done) marker_d = 1'b1;
    else marker_d = marker_q;

    // frame_done discards the partial bank and swallows any same-cycle byte.
    if (frame_done) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (pix_valid) begin
      case (wstate_q)
        W_FILL: begin
          stg_v_d    = 1'b1;
          stg_bank_d = wbank_q;
          stg_addr_d = HDR_ADDR + ADDR_W'(cnt_q);
          stg_data_d = cam_data;
          if (cnt_q == LAST_CNT) begin
            full_d[wbank_q] = 1'b1;
            cnt_d           = {CNT_W{1'b0}};
            wbank_d         = ~wbank_q;
            if (full_free_s[~wbank_q]) wstate_d = W_STALL;
            else wstate_d = W_FILL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        W_STALL: begin
          overflow_d = 1'b1;
          drop_cnt_d = (&drop_cnt) ? drop_cnt : drop_cnt + DROP_W'(1);
        end
        default: wstate_d = W_FILL;
      endcase
    end else begin
      cnt_d = cnt_q;
    end

    if (wstate_q == W_STALL && clr_bank_s[wbank_q]) wstate_d = W_FILL;
    else wstate_d = wstate_d;

    case (sstate_q)
      S_IDLE: begin
        if (job_s) begin
          sstate_d    = S_BUSY;
          send_req_d  = 1'b1;
          send_rom_d  = pick_rom_s;
          send_bank_d = pick_rom_s ? 1'b0 : pick_bank_s;
        end else begin
          sstate_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (eth_finish) begin
          sstate_d   = S_IDLE;
          send_req_d = 1'b0;
        end else begin
          sstate_d = S_BUSY;
        end
      end
      default: begin
        sstate_d   = S_IDLE;
        send_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q    <= W_FILL;
      sstate_q    <= S_IDLE;
      wbank_q     <= 1'b0;
      full_q      <= 2'b00;
      cnt_q       <= {CNT_W{1'b0}};
      marker_q    <= 1'b0;
      stg_v_q     <= 1'b0;
      stg_bank_q  <= 1'b0;
      stg_addr_q  <= {ADDR_W{1'b0}};
      stg_data_q  <= {DATA_W{1'b0}};
      ram_wr_en   <= 1'b0;
      ram_wr_bank <= 1'b0;
      ram_addr    <= {ADDR_W{1'b0}};
      ram_din     <= {DATA_W{1'b0}};
      send_req    <= 1'b0;
      send_bank   <= 1'b0;
      send_rom    <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= {DROP_W{1'b0}};
    end else begin
      wstate_q    <= wstate_d;
      sstate_q    <= sstate_d;
      wbank_q     <= wbank_d;
      full_q      <= full_d;
      cnt_q       <= cnt_d;
      marker_q    <= marker_d;
      stg_v_q     <= stg_v_d;
      stg_bank_q  <= stg_bank_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      ram_wr_en   <= stg_v_q;
      ram_wr_bank <= stg_bank_q;
      ram_addr    <= stg_addr_q;
      ram_din     <= stg_data_q;
      send_req    <= send_req_d;
      send_bank   <= send_bank_d;
      send_rom    <= send_rom_d;
      overflow    <= overflow_d;
      drop_cnt    <= drop_cnt_d;
    end
  end

`ifdef SEQ_TAG_EN
  logic [15:0] seq_q;

  // Counts completed sends; the tag is latched as each new request is raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q    <= 16'd0;
      send_seq <= 16'd0;
    end else begin
      if (fin_s) seq_q <= seq_q + 16'd1;
      if (job_s) send_seq <= seq_q;
    end
  end
`else
  assign send_seq = 16'd0;
`endif

endmodule
